// File: rtl/hex_entry_pkg.sv
// Shared types and defaults for the hex entry capture block.
// Holds the FSM state encoding and default digit/debounce sizes.
package hex_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_DEB_CYCLES = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, stability counter, and a
// single-cycle press pulse on an accepted 0->1 level change.
module btn_debounce
  import hex_entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNTW = $clog2(DEB_CYCLES);
  localparam logic [CNTW-1:0] CMAX = CNTW'(DEB_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic            prev;
  logic            lvl;
  logic [CNTW-1:0] cnt;

  // Sync the raw level, count equal samples, accept after the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      prev  <= s2;
      press <= 1'b0;
      if (s2 != prev) begin
        cnt <= '0;
      end else if (cnt != CMAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        if (s2 && !lvl) press <= 1'b1;
        lvl <= s2;
      end
    end
  end

endmodule

// File: rtl/hex_entry_capture.sv
// Switch word entry: syncs switches, commits on debounced ENTER,
// and hands the word downstream over valid/ready.
module hex_entry_capture
  import hex_entry_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SERIAL     = 0,
  localparam int W  = DIGITS * DIGIT_W,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  switch_in,
  input  logic          enter_btn,
  input  logic          clr_btn,
  input  logic          usr_ready,
  output logic [W-1:0]  usr_input,
  output logic          usr_valid,
  output logic [W-1:0]  live_value,
  output logic [CW-1:0] digit_count,
  output logic          overrun
);

  logic [W-1:0]  sw1;
  logic [W-1:0]  sw2;
  logic [W-1:0]  sw_img;
  logic [W-1:0]  part;
  logic [W-1:0]  shifted;
  logic          enter_ev;
  logic          clr_ev;

  state_t        state;
  state_t        n_state;
  logic [W-1:0]  n_input;
  logic          n_valid;
  logic [W-1:0]  n_part;
  logic [CW-1:0] n_count;
  logic          n_overrun;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clk   (clk),
    .rst   (rst),
    .btn   (enter_btn),
    .press (enter_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (clr_btn),
    .press (clr_ev)
  );

  // Two sync stages then a registered image of the switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw1    <= '0;
      sw2    <= '0;
      sw_img <= '0;
    end else begin
      sw1    <= switch_in;
      sw2    <= sw1;
      sw_img <= sw2;
    end
  end

  assign shifted = (part << DIGIT_W) | W'(sw2[DIGIT_W-1:0]);
  assign live_value = (SERIAL != 0) ? part : sw_img;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      usr_input   <= '0;
      usr_valid   <= 1'b0;
      part        <= '0;
      digit_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= n_state;
      usr_input   <= n_input;
      usr_valid   <= n_valid;
      part        <= n_part;
      digit_count <= n_count;
      overrun     <= n_overrun;
    end
  end

  // Next-state: clear dominates, then per-state enter/ready handling.
  always_comb begin
    n_state   = state;
    n_input   = usr_input;
    n_valid   = usr_valid;
    n_part    = part;
    n_count   = digit_count;
    n_overrun = overrun;
    if (clr_ev) begin
      n_state   = IDLE;
      n_valid   = 1'b0;
      n_part    = '0;
      n_count   = '0;
      n_overrun = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enter_ev) begin
            if (SERIAL == 0) begin
              n_input = sw2;
              n_valid = 1'b1;
              n_state = HOLD;
            end else if (DIGITS == 1) begin
              n_input = shifted;
              n_valid = 1'b1;
              n_part  = '0;
              n_count = '0;
              n_state = HOLD;
            end else begin
              n_part  = shifted;
              n_count = CW'(1);
              n_state = COLLECT;
            end
          end
        end
        COLLECT: begin
          if (enter_ev) begin
            if (digit_count == CW'(DIGITS - 1)) begin
              n_input = shifted;
              n_valid = 1'b1;
              n_part  = '0;
              n_count = '0;
              n_state = HOLD;
            end else begin
              n_part  = shifted;
              n_count = digit_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (usr_ready) begin
            n_valid = 1'b0;
            n_state = IDLE;
          end else if (enter_ev) begin
            n_overrun = 1'b1;
          end
        end
        default: begin
          n_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_entry_capture.sv
// Bench for hex_entry_capture: parallel, serial and 8-digit
// instances driven with bouncy presses and random words.
module tb_hex_entry_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  enter_b;
  logic [2:0]  clr_b;
  logic [2:0]  rdy;
  logic [15:0] sw_a;
  logic [15:0] sw_s;
  logic [31:0] sw_w;

  logic [15:0] ui_a, lv_a, ui_s, lv_s;
  logic [31:0] ui_w, lv_w;
  logic        va, vs, vw, ov_a, ov_s, ov_w;
  logic [2:0]  dc_a, dc_s;
  logic [3:0]  dc_w;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hex_entry_capture #(
    .DIGITS(4), .DIGIT_W(4), .DEB_CYCLES(4), .SERIAL(0)
  ) dut_a (
    .clk(clk), .rst(rst), .switch_in(sw_a),
    .enter_btn(enter_b[0]), .clr_btn(clr_b[0]), .usr_ready(rdy[0]),
    .usr_input(ui_a), .usr_valid(va), .live_value(lv_a),
    .digit_count(dc_a), .overrun(ov_a)
  );

  hex_entry_capture #(
    .DIGITS(4), .DIGIT_W(4), .DEB_CYCLES(4), .SERIAL(1)
  ) dut_s (
    .clk(clk), .rst(rst), .switch_in(sw_s),
    .enter_btn(enter_b[1]), .clr_btn(clr_b[1]), .usr_ready(rdy[1]),
    .usr_input(ui_s), .usr_valid(vs), .live_value(lv_s),
    .digit_count(dc_s), .overrun(ov_s)
  );

  hex_entry_capture #(
    .DIGITS(8), .DIGIT_W(4), .DEB_CYCLES(4), .SERIAL(0)
  ) dut_w (
    .clk(clk), .rst(rst), .switch_in(sw_w),
    .enter_btn(enter_b[2]), .clr_btn(clr_b[2]), .usr_ready(rdy[2]),
    .usr_input(ui_w), .usr_valid(vw), .live_value(lv_w),
    .digit_count(dc_w), .overrun(ov_w)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] em, input logic [2:0] cm,
                       input int bounces);
    for (int b = 0; b < bounces; b++) begin
      enter_b = em; clr_b = cm; cyc(1);
      enter_b = '0; clr_b = '0; cyc(1);
    end
    enter_b = em; clr_b = cm; cyc(10);
    enter_b = '0; clr_b = '0; cyc(10);
  endtask

  task automatic handshake(input int idx);
    rdy[idx] = 1'b1; cyc(1); rdy[idx] = 1'b0;
  endtask

  task automatic test_reset;
    sw_a = 16'h1357; sw_s = 16'h2468; sw_w = 32'h0BADF00D;
    rst = 1'b1; cyc(4);
    n_checks += 7;
    if (va !== 1'b0 || vs !== 1'b0 || vw !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b%b%b want 000", va, vs, vw);
    end
    if (ui_a !== 16'h0 || ui_s !== 16'h0 || ui_w !== 32'h0) begin
      n_fail++; $display("FAIL reset_input got %h %h %h want 0", ui_a, ui_s, ui_w);
    end
    if (lv_a !== 16'h0) begin
      n_fail++; $display("FAIL reset_live_a got %h want 0", lv_a);
    end
    if (lv_s !== 16'h0) begin
      n_fail++; $display("FAIL reset_live_s got %h want 0", lv_s);
    end
    if (lv_w !== 32'h0) begin
      n_fail++; $display("FAIL reset_live_w got %h want 0", lv_w);
    end
    if (dc_a !== 3'd0 || dc_s !== 3'd0 || dc_w !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got %0d %0d %0d want 0", dc_a, dc_s, dc_w);
    end
    if (ov_a !== 1'b0 || ov_s !== 1'b0 || ov_w !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun got %b%b%b want 000", ov_a, ov_s, ov_w);
    end
    rst = 1'b0; cyc(5);
  endtask

  task automatic test_parallel;
    logic [15:0] prev;
    logic [15:0] want;
    prev = sw_a;
    sw_a = 16'hBEEF;
    cyc(2);
    n_checks++;
    if (lv_a !== prev) begin
      n_fail++; $display("FAIL par_latency_early got %h want %h", lv_a, prev);
    end
    cyc(1);
    n_checks++;
    if (lv_a !== 16'hBEEF) begin
      n_fail++; $display("FAIL par_latency got %h want BEEF", lv_a);
    end
    press(3'b001, 3'b000, 3);
    n_checks++;
    if (va !== 1'b1 || ui_a !== 16'hBEEF) begin
      n_fail++; $display("FAIL par_commit got v=%b %h want v=1 BEEF", va, ui_a);
    end
    n_checks++;
    if (dc_a !== 3'd0) begin
      n_fail++; $display("FAIL par_count got %0d want 0", dc_a);
    end
    handshake(0);
    n_checks++;
    if (va !== 1'b0 || ui_a !== 16'hBEEF) begin
      n_fail++; $display("FAIL par_release got v=%b %h want v=0 BEEF", va, ui_a);
    end
    for (int i = 0; i < 4; i++) begin
      want = 16'($urandom());
      sw_a = want;
      cyc(4);
      press(3'b001, 3'b000, $urandom_range(0, 4));
      n_checks++;
      if (va !== 1'b1 || ui_a !== want) begin
        n_fail++; $display("FAIL par_rand%0d got v=%b %h want v=1 %h", i, va, ui_a, want);
      end
      handshake(0);
    end
  endtask

  task automatic test_bounce;
    int seen;
    seen = 0;
    sw_a = 16'h4321;
    for (int i = 0; i < 20; i++) begin
      enter_b[0] = (i % 4) < 2;
      cyc(1);
      if (va === 1'b1) seen++;
    end
    enter_b[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (va === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL bounce_reject got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d);
    sw_s = 16'($urandom());
    sw_s[3:0] = d;
    cyc(3);
    press(3'b010, 3'b000, $urandom_range(0, 3));
  endtask

  task automatic test_serial;
    logic [15:0] word;
    logic [3:0] d;
    word = 16'h0;
    for (int i = 1; i <= 4; i++) begin
      enter_digit(4'(i));
      word = word * 16 + 16'(i);
      if (i < 4) begin
        n_checks++;
        if (lv_s !== word || dc_s !== 3'(i) || vs !== 1'b0) begin
          n_fail++;
          $display("FAIL ser_digit%0d got %h cnt=%0d v=%b want %h cnt=%0d v=0",
                   i, lv_s, dc_s, vs, word, i);
        end
      end
    end
    n_checks++;
    if (vs !== 1'b1 || ui_s !== 16'h1234 || dc_s !== 3'd0) begin
      n_fail++;
      $display("FAIL ser_commit got v=%b %h cnt=%0d want v=1 1234 cnt=0", vs, ui_s, dc_s);
    end
    handshake(1);
    for (int k = 0; k < 3; k++) begin
      word = 16'h0;
      for (int i = 0; i < 4; i++) begin
        d = 4'($urandom());
        enter_digit(d);
        word = word * 16 + 16'(d);
      end
      n_checks++;
      if (vs !== 1'b1 || ui_s !== word) begin
        n_fail++; $display("FAIL ser_rand%0d got v=%b %h want v=1 %h", k, vs, ui_s, word);
      end
      handshake(1);
    end
  endtask

  task automatic test_overrun;
    sw_a = 16'hA5A5; cyc(4);
    press(3'b001, 3'b000, 2);
    n_checks++;
    if (va !== 1'b1 || ui_a !== 16'hA5A5 || ov_a !== 1'b0) begin
      n_fail++; $display("FAIL ovr_first got v=%b %h o=%b want v=1 A5A5 o=0", va, ui_a, ov_a);
    end
    sw_a = 16'h0000; cyc(4);
    press(3'b001, 3'b000, 1);
    n_checks++;
    if (va !== 1'b1 || ui_a !== 16'hA5A5 || ov_a !== 1'b1) begin
      n_fail++; $display("FAIL ovr_second got v=%b %h o=%b want v=1 A5A5 o=1", va, ui_a, ov_a);
    end
    press(3'b000, 3'b001, 2);
    n_checks++;
    if (va !== 1'b0 || ov_a !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear got v=%b o=%b want v=0 o=0", va, ov_a);
    end
  endtask

  task automatic test_clr_wins;
    sw_a = 16'h7E57; cyc(4);
    press(3'b001, 3'b001, 2);
    n_checks++;
    if (va !== 1'b0) begin
      n_fail++; $display("FAIL clr_wins got v=%b want v=0", va);
    end
    press(3'b001, 3'b000, 0);
    n_checks++;
    if (va !== 1'b1 || ui_a !== 16'h7E57) begin
      n_fail++; $display("FAIL clr_after got v=%b %h want v=1 7E57", va, ui_a);
    end
    handshake(0);
  endtask

  task automatic test_reset_mid_serial;
    logic [15:0] word;
    enter_digit(4'($urandom()));
    enter_digit(4'($urandom()));
    rst = 1'b1; cyc(2);
    n_checks++;
    if (lv_s !== 16'h0 || dc_s !== 3'd0 || vs !== 1'b0 || ui_s !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid got lv=%h cnt=%0d v=%b ui=%h want all 0", lv_s, dc_s, vs, ui_s);
    end
    rst = 1'b0; cyc(3);
    word = 16'h0;
    for (int i = 0; i < 4; i++) begin
      enter_digit(4'(9 - i));
      word = word * 16 + 16'(9 - i);
    end
    n_checks++;
    if (vs !== 1'b1 || ui_s !== 16'h9876 || word !== 16'h9876) begin
      n_fail++; $display("FAIL rst_mid_after got v=%b %h want v=1 9876", vs, ui_s);
    end
    handshake(1);
  endtask

  task automatic test_wide;
    logic [31:0] prev;
    logic [31:0] want;
    prev = sw_w;
    sw_w = 32'hDEADBEEF;
    cyc(2);
    n_checks++;
    if (lv_w !== prev) begin
      n_fail++; $display("FAIL wide_latency_early got %h want %h", lv_w, prev);
    end
    cyc(1);
    n_checks++;
    if (lv_w !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wide_latency got %h want DEADBEEF", lv_w);
    end
    press(3'b100, 3'b000, 3);
    n_checks++;
    if (vw !== 1'b1 || ui_w !== 32'hDEADBEEF || dc_w !== 4'd0) begin
      n_fail++; $display("FAIL wide_commit got v=%b %h want v=1 DEADBEEF", vw, ui_w);
    end
    handshake(2);
    n_checks++;
    if (vw !== 1'b0) begin
      n_fail++; $display("FAIL wide_release got v=%b want 0", vw);
    end
    want = $urandom();
    sw_w = want; cyc(4);
    press(3'b100, 3'b000, 1);
    n_checks++;
    if (vw !== 1'b1 || ui_w !== want) begin
      n_fail++; $display("FAIL wide_rand got v=%b %h want v=1 %h", vw, ui_w, want);
    end
    handshake(2);
  endtask

  initial begin
    rst = 1'b1;
    enter_b = '0; clr_b = '0; rdy = '0;
    sw_a = '0; sw_s = '0; sw_w = '0;
    test_reset();
    test_parallel();
    test_bounce();
    test_serial();
    test_overrun();
    test_clr_wins();
    test_reset_mid_serial();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
